// File: rtl/duck_hunt_pkg.sv
// duck_hunt_pkg: shared state encoding and width helpers for the light-gun controller
package duck_hunt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BLACK,
        TGT,
        RESULT
    } gun_state_t;

    // Index fields are one bit wider than the minimum so a count of 1 still yields a 1-bit field
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/light_gun_ctrl_if.sv
// light_gun_if: frame timing, gun inputs and flash/result outputs of the light-gun controller
interface light_gun_if
    import duck_hunt_pkg::*;
#(
    parameter int N_GUNS    = 2,
    parameter int N_TARGETS = 2
);
    logic                            frame_start;
    logic                            valid;
    logic [N_GUNS-1:0]               trigger;
    logic [N_GUNS-1:0]               detect;
    logic                            flash_black;
    logic                            flash_target;
    logic [idx_w(N_TARGETS)-1:0]     flash_idx;
    logic                            busy;
    logic                            hit_valid;
    logic                            miss_valid;
    logic [idx_w(N_GUNS)-1:0]        res_gun;
    logic [idx_w(N_TARGETS)-1:0]     res_target;

    modport master (
        output frame_start, valid, trigger, detect,
        input  flash_black, flash_target, flash_idx, busy,
        input  hit_valid, miss_valid, res_gun, res_target
    );

    modport slave (
        input  frame_start, valid, trigger, detect,
        output flash_black, flash_target, flash_idx, busy,
        output hit_valid, miss_valid, res_gun, res_target
    );
endinterface

// File: rtl/gun_debounce.sv
// gun_debounce: synchronises one raw trigger and emits a 1-cycle pulse on each debounced press
module gun_debounce #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accept the new level only after DEBOUNCE_CYC consecutive samples disagree with the held one
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = s2_q;
                press_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; reset reloads the released level
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/light_gun_ctrl.sv
// light_gun_ctrl: runs the black/target flash sequence for a fired gun and reports hit or miss
module light_gun_ctrl
    import duck_hunt_pkg::*;
#(
    parameter int N_GUNS       = 2,
    parameter int N_TARGETS    = 2,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int DETECT_MIN   = 64
) (
    input logic        clk,
    input logic        reset,
    light_gun_if.slave bus
);
    localparam int GW = idx_w(N_GUNS);
    localparam int TW = idx_w(N_TARGETS);
    localparam int CW = $clog2(DETECT_MIN + 1);

    logic [N_GUNS-1:0] press;
    logic [N_GUNS-1:0] det_s1_q, det_s2_q;
    gun_state_t        state_q, state_d;
    logic [GW-1:0]     gun_q, gun_d, sel;
    logic [TW-1:0]     t_q, t_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flash_black_q, flash_black_d;
    logic              flash_target_q, flash_target_d;
    logic [TW-1:0]     flash_idx_q, flash_idx_d;
    logic              busy_q, busy_d;
    logic              hit_valid_q, hit_valid_d;
    logic              miss_valid_q, miss_valid_d;
    logic [GW-1:0]     res_gun_q, res_gun_d;
    logic [TW-1:0]     res_target_q, res_target_d;
    logic              det_sel, light;

    for (genvar g = 0; g < N_GUNS; g++) begin : g_db
        gun_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.trigger[g]),
            .press (press[g])
        );
    end

    // Lowest-index press wins; only the latched gun's synchronised photodiode matters
    always_comb begin
        sel     = '0;
        det_sel = 1'b0;
        for (int i = N_GUNS - 1; i >= 0; i--) begin
            if (press[i]) sel = GW'(i);
        end
        for (int i = 0; i < N_GUNS; i++) begin
            if (gun_q == GW'(i)) det_sel = det_s2_q[i];
        end
        light = cnt_q >= CW'(DETECT_MIN);
    end

    // Shot sequencer: result flops are loaded on the deciding frame_start so they line up with RESULT
    always_comb begin
        state_d        = state_q;
        gun_d          = gun_q;
        t_d            = t_q;
        cnt_d          = cnt_q;
        flash_black_d  = flash_black_q;
        flash_target_d = flash_target_q;
        flash_idx_d    = flash_idx_q;
        hit_valid_d    = 1'b0;
        miss_valid_d   = 1'b0;
        res_gun_d      = res_gun_q;
        res_target_d   = res_target_q;
        if ((state_q == BLACK || state_q == TGT) && bus.valid && det_sel && !light) cnt_d = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (|press) begin
                    gun_d   = sel;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.frame_start) begin
                    state_d       = BLACK;
                    flash_black_d = 1'b1;
                    cnt_d         = '0;
                end
            end
            BLACK: begin
                if (bus.frame_start) begin
                    flash_black_d = 1'b0;
                    cnt_d         = '0;
                    if (light) begin
                        state_d      = RESULT;
                        miss_valid_d = 1'b1;
                        res_gun_d    = gun_q;
                        res_target_d = '0;
                    end else begin
                        state_d        = TGT;
                        t_d            = '0;
                        flash_target_d = 1'b1;
                        flash_idx_d    = '0;
                    end
                end
            end
            TGT: begin
                if (bus.frame_start) begin
                    cnt_d = '0;
                    if (light || t_q == TW'(N_TARGETS - 1)) begin
                        state_d        = RESULT;
                        flash_target_d = 1'b0;
                        flash_idx_d    = '0;
                        hit_valid_d    = light;
                        miss_valid_d   = !light;
                        res_gun_d      = gun_q;
                        res_target_d   = light ? t_q : '0;
                    end else begin
                        t_d         = t_q + 1'b1;
                        flash_idx_d = t_q + 1'b1;
                    end
                end
            end
            RESULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // State and output registers; reset aborts any shot without a result pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            det_s1_q       <= '0;
            det_s2_q       <= '0;
            state_q        <= IDLE;
            gun_q          <= '0;
            t_q            <= '0;
            cnt_q          <= '0;
            flash_black_q  <= 1'b0;
            flash_target_q <= 1'b0;
            flash_idx_q    <= '0;
            busy_q         <= 1'b0;
            hit_valid_q    <= 1'b0;
            miss_valid_q   <= 1'b0;
            res_gun_q      <= '0;
            res_target_q   <= '0;
        end else begin
            det_s1_q       <= bus.detect;
            det_s2_q       <= det_s1_q;
            state_q        <= state_d;
            gun_q          <= gun_d;
            t_q            <= t_d;
            cnt_q          <= cnt_d;
            flash_black_q  <= flash_black_d;
            flash_target_q <= flash_target_d;
            flash_idx_q    <= flash_idx_d;
            busy_q         <= busy_d;
            hit_valid_q    <= hit_valid_d;
            miss_valid_q   <= miss_valid_d;
            res_gun_q      <= res_gun_d;
            res_target_q   <= res_target_d;
        end
    end

    assign bus.flash_black  = flash_black_q;
    assign bus.flash_target = flash_target_q;
    assign bus.flash_idx    = flash_idx_q;
    assign bus.busy         = busy_q;
    assign bus.hit_valid    = hit_valid_q;
    assign bus.miss_valid   = miss_valid_q;
    assign bus.res_gun      = res_gun_q;
    assign bus.res_target   = res_target_q;
endmodule
